// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution frame sequencer.
package conv_pkg;

    localparam int NUM_TAPS   = 9;
    localparam int CENTRE_TAP = 4;
    localparam int LAST_TAP   = 8;
    localparam int TAP_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_WIN = 3'd1,
        S_MAC      = 3'd2,
        S_RESULT   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/conv_scheduler_raster_coord_counter.sv
// Raster-order (x,y) walker over an IMG_W x IMG_H image with border/last flags.
module raster_coord_counter #(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 12,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               is_border,
    output logic               is_last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    // Past the final pixel both coordinates wrap, so the frame ends at (0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x != X_LAST) begin
                x <= x + 1'b1;
            end else begin
                x <= '0;
                y <= (y != Y_LAST) ? y + 1'b1 : '0;
            end
        end
    end

    assign is_border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
    assign is_last   = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/conv_scheduler.sv
// Frame sequencer: window handshake, nine-tap MAC burst or centre bypass, result handshake.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 12,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    output logic               busy,
    input  logic               win_valid,
    output logic               win_ready,
    output logic [3:0]         pix_sel,
    output logic [3:0]         coef_sel,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               bypass,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_done,
    output logic [2:0]         state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // win_ready and res_valid are decoded from state only, never from inputs.
    state_t             state, state_nxt;
    logic [TAP_W-1:0]   tap, tap_nxt;
    logic               coord_clear, coord_advance;
    logic               is_border, is_last;

    raster_coord_counter #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .COORD_W (COORD_W)
    ) u_coord (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (coord_clear),
        .advance   (coord_advance),
        .x         (x),
        .y         (y),
        .is_border (is_border),
        .is_last   (is_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            tap   <= '0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tap_nxt       = tap;
        coord_clear   = 1'b0;
        coord_advance = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_WAIT_WIN;
                    coord_clear = 1'b1;
                end
            end
            S_WAIT_WIN: begin
                if (win_valid) begin
                    if (is_border) begin
                        state_nxt = S_RESULT;
                    end else begin
                        state_nxt = S_MAC;
                        tap_nxt   = '0;
                    end
                end
            end
            S_MAC: begin
                if (tap == TAP_W'(LAST_TAP)) begin
                    state_nxt = S_RESULT;
                    tap_nxt   = '0;
                end else begin
                    tap_nxt = tap + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    coord_advance = 1'b1;
                    state_nxt     = is_last ? S_DONE : S_WAIT_WIN;
                end
            end
            S_DONE: begin
                state_nxt   = S_IDLE;
                coord_clear = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                tap_nxt   = '0;
            end
        endcase
    end

    // Kernel is applied flipped: coefficient index mirrors the pixel index.
    assign busy       = (state != S_IDLE);
    assign win_ready  = (state == S_WAIT_WIN);
    assign acc_en     = (state == S_MAC);
    assign pix_sel    = acc_en ? tap : 4'd0;
    assign coef_sel   = acc_en ? (TAP_W'(LAST_TAP) - tap) : 4'd0;
    assign acc_clr    = acc_en && (tap == '0);
    assign res_valid  = (state == S_RESULT);
    assign bypass     = res_valid && is_border;
    assign frame_done = (state == S_DONE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler: 4x3 frames (directed + random) and a 3x3 frame.
module tb_conv_scheduler;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic resetn;
  logic start, win_valid, res_ready;
  logic busy, win_ready, acc_clr, acc_en, bypass, res_valid, frame_done;
  logic [3:0] pix_sel, coef_sel;
  logic [CW-1:0] x, y;
  logic [2:0] state_dbg;

  logic start3;
  logic busy3, win_ready3, acc_clr3, acc_en3, bypass3, res_valid3, frame_done3;
  logic [3:0] pix_sel3, coef_sel3;
  logic [CW-1:0] x3, y3;
  logic [2:0] state_dbg3;

  int n_assert = 0;
  int n_fail   = 0;

  int m_phase, m_tap, m_x, m_y;

  logic [2*CW:0] exp_q[$];
  logic [2*CW:0] got_q[$];

  always #5 clk = ~clk;

  conv_scheduler #(.IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy),
    .win_valid(win_valid), .win_ready(win_ready), .pix_sel(pix_sel), .coef_sel(coef_sel),
    .acc_clr(acc_clr), .acc_en(acc_en), .bypass(bypass), .res_valid(res_valid),
    .res_ready(res_ready), .x(x), .y(y), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  conv_scheduler #(.IMG_W(3), .IMG_H(3), .COORD_W(CW)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .busy(busy3),
    .win_valid(1'b1), .win_ready(win_ready3), .pix_sel(pix_sel3), .coef_sel(coef_sel3),
    .acc_clr(acc_clr3), .acc_en(acc_en3), .bypass(bypass3), .res_valid(res_valid3),
    .res_ready(1'b1), .x(x3), .y(y3), .frame_done(frame_done3), .state_dbg(state_dbg3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_b(input int xx, input int yy, input int w, input int h);
    return (xx == 0) || (xx == w - 1) || (yy == 0) || (yy == h - 1);
  endfunction

  task automatic check_outputs();
    bit mac, res;
    mac = (m_phase == 2);
    res = (m_phase == 3);
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("win_ready", 32'(win_ready), 32'(m_phase == 1));
    chk("acc_en", 32'(acc_en), 32'(mac));
    chk("pix_sel", 32'(pix_sel), mac ? 32'(m_tap) : 32'd0);
    chk("coef_sel", 32'(coef_sel), mac ? 32'(8 - m_tap) : 32'd0);
    chk("acc_clr", 32'(acc_clr), 32'(mac && m_tap == 0));
    chk("res_valid", 32'(res_valid), 32'(res));
    chk("bypass", 32'(bypass), 32'(res && is_b(m_x, m_y, W, H)));
    chk("x", 32'(x), 32'(m_x));
    chk("y", 32'(y), 32'(m_y));
    chk("frame_done", 32'(frame_done), 32'(m_phase == 4));
  endtask

  // Transaction-level expectation of what the sequencer does with the inputs of one edge.
  task automatic model_adv(input bit st, input bit wv, input bit rr);
    case (m_phase)
      0: if (st) begin m_phase = 1; m_x = 0; m_y = 0; end
      1: if (wv) begin
           if (is_b(m_x, m_y, W, H)) m_phase = 3;
           else begin m_phase = 2; m_tap = 0; end
         end
      2: if (m_tap == 8) begin m_phase = 3; m_tap = 0; end else m_tap++;
      3: if (rr) begin
           if (m_x < W - 1) begin m_x++; m_phase = 1; end
           else begin
             m_x = 0;
             if (m_y < H - 1) begin m_y++; m_phase = 1; end
             else begin m_y = 0; m_phase = 4; end
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input bit st, input bit wv, input bit rr);
    check_outputs();
    start = st; win_valid = wv; res_ready = rr;
    @(posedge clk); #1;
    model_adv(st, wv, rr);
  endtask

  // mode 0: inputs tied high; 1: random; 2: 7-cycle window gaps and 5-cycle result stalls.
  task automatic run_frame(input int mode, input bit abort_mid);
    int busy_cnt, done_cnt, wc, rc, ni, nb, busy_exp;
    bit st, wv, rr, started, finished;
    busy_cnt = 0; done_cnt = 0; wc = 0; rc = 0; started = 0; finished = 0;
    exp_q.delete(); got_q.delete();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back({CW'(xx), CW'(yy), 1'(is_b(xx, yy, W, H))});
    for (int c = 0; c < 4000; c++) begin
      if (started && m_phase == 0) begin finished = 1; break; end
      if (abort_mid && m_phase == 2 && m_tap == 5 && m_x == 1 && m_y == 1) return;
      wv = 1; rr = 1;
      st = (m_phase == 0) ? 1'b1 : (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0);
      if (mode == 1) begin
        wv = ($urandom_range(0, 2) != 0);
        rr = ($urandom_range(0, 2) != 0);
      end else if (mode == 2) begin
        wv = (m_phase == 1) ? (wc == 7) : 1'b1;
        wc = (m_phase == 1 && !wv) ? wc + 1 : 0;
        if (m_phase == 3 && !is_b(m_x, m_y, W, H)) rr = (rc == 5);
        rc = (m_phase == 3 && !rr) ? rc + 1 : 0;
      end
      if (busy) busy_cnt++;
      if (frame_done) done_cnt++;
      if (res_valid && rr) got_q.push_back({x, y, bypass});
      step(st, wv, rr);
      started = 1;
    end
    chk("frame_timeout", 32'(finished), 32'd1);
    chk("frame_done_count", 32'(done_cnt), 32'd1);
    chk("result_count", 32'(got_q.size()), 32'(W * H));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("result_order", 32'(got_q[i]), 32'(exp_q[i]));
    ni = (W - 2) * (H - 2);
    nb = W * H - ni;
    busy_exp = (mode == 0) ? 11 * ni + 2 * nb + 1 : nb * (2 + 7) + ni * (11 + 7 + 5) + 1;
    if (mode != 1) chk("frame_cycles", 32'(busy_cnt), 32'(busy_exp));
  endtask

  initial begin
    int mac3, done3;
    start = 0; win_valid = 0; res_ready = 0; start3 = 0;
    m_phase = 0; m_tap = 0; m_x = 0; m_y = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 0);
    run_frame(2, 0);
    for (int k = 0; k < 3; k++) run_frame(1, 0);

    // Abort at tap 5 of pixel (1,1) with an asynchronous reset.
    run_frame(0, 1);
    chk("abort_reached", 32'(m_phase == 2 && m_tap == 5), 32'd1);
    #2 resetn = 1'b0;
    #1;
    m_phase = 0; m_tap = 0; m_x = 0; m_y = 0;
    check_outputs();
    repeat (2) begin @(posedge clk); #1; check_outputs(); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    step(0, 1, 1);
    run_frame(0, 0);

    // 3x3 image: one interior pixel, eight bypassed border pixels.
    exp_q.delete(); got_q.delete();
    for (int yy = 0; yy < 3; yy++)
      for (int xx = 0; xx < 3; xx++)
        exp_q.push_back({CW'(xx), CW'(yy), 1'(is_b(xx, yy, 3, 3))});
    mac3 = 0; done3 = 0;
    start3 = 1;
    @(posedge clk); #1;
    start3 = 0;
    for (int c = 0; c < 60; c++) begin
      if (res_valid3) got_q.push_back({x3, y3, bypass3});
      if (acc_en3) mac3++;
      if (frame_done3) done3++;
      @(posedge clk); #1;
    end
    chk("img3_result_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("img3_result", 32'(got_q[i]), 32'(exp_q[i]));
    chk("img3_mac_cycles", 32'(mac3), 32'd9);
    chk("img3_frame_done", 32'(done3), 32'd1);
    chk("img3_idle", 32'(busy3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
